// File: rtl/seq_symbol_ser.sv
`default_nettype none
// ============================================================================
//  Module   : seq_symbol_ser
//  Purpose  : Word-to-symbol serializer feeding the two-bit-symbol sequence
//             detector. Accepts WORD_W-bit words over valid/ready and emits
//             them MSB-first as WORD_W/2 two-bit symbols (B = MSB, A = LSB),
//             one symbol per unheld clock. A one-deep pending register lets
//             consecutive words stream with no idle cycle between them.
//  Ports    : clk        rising-edge clock
//             clr        synchronous active-high reset
//             din        word to serialize
//             din_valid  din is offered
//             din_ready  block can take a word (transfer = valid & ready)
//             hold       freeze shifting, current symbol is held
//             B, A       current symbol (MSB, LSB)
//             sym_valid  B/A carry a symbol consumed at this edge
//             last       current symbol is the final one of its word
//             busy       active or pending word present
//  Revision : 1.0  initial release
// ============================================================================
module seq_symbol_ser #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              hold,
  output logic              B,
  output logic              A,
  output logic              sym_valid,
  output logic              last,
  output logic              busy
);

  localparam int SYM_N = WORD_W / 2;
  localparam int CNT_W = (SYM_N > 1) ? $clog2(SYM_N) : 1;
  localparam logic [CNT_W-1:0] c_last_sym = CNT_W'(SYM_N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;

  logic                w_xfer;
  logic                w_adv;
  logic                w_eow;

  // Ready is gated by clr so a word offered during reset is never taken.
  assign din_ready = !clr && !pend_full_q;
  assign w_xfer    = din_valid && din_ready;
  assign w_adv     = (state_q == ST_SHIFT) && !hold;
  assign w_eow     = w_adv && (cnt_q == c_last_sym);

  assign B         = shreg_q[WORD_W-1];
  assign A         = shreg_q[WORD_W-2];
  assign sym_valid = w_adv;
  assign last      = w_adv && (cnt_q == c_last_sym);
  assign busy      = (state_q == ST_SHIFT) || pend_full_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    case (state_q)
      ST_IDLE: begin
        // Pending is always empty in IDLE, so a transfer loads directly.
        if (w_xfer) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_eow) begin
          cnt_d = '0;
          if (pend_full_q) begin
            // din_ready is low here, so no transfer can collide with the drain.
            shreg_d     = pend_q;
            pend_full_d = 1'b0;
          end else if (w_xfer) begin
            // Bypass: the new word goes straight to the shifter, no gap.
            shreg_d = din;
          end else begin
            shreg_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          if (w_adv) begin
            shreg_d = {shreg_q[WORD_W-3:0], 2'b00};
            cnt_d   = cnt_q + 1'b1;
          end
          if (w_xfer) begin
            pend_d      = din;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_symbol_ser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_symbol_ser
//  Purpose  : Self-checking bench for seq_symbol_ser. A word-level reference
//             model (current word + symbol index, optional pending word)
//             predicts every output each cycle; directed steps follow the
//             feature list, then a randomized phase exercises mixed traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_symbol_ser;

  localparam int W = 32;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         hold;
  logic         B;
  logic         A;
  logic         sym_valid;
  logic         last;
  logic         busy;

  seq_symbol_ser #(.WORD_W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .hold      (hold),
    .B         (B),
    .A         (A),
    .sym_valid (sym_valid),
    .last      (last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: word being emitted, its symbol index, pending word.
  bit           m_cur  = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_idx  = 0;
  bit           m_pend = 1'b0;
  logic [W-1:0] m_pword = '0;

  logic [1:0]   sym_log[$];
  logic [1:0]   ref_seq[16] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3,
                                2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model with the same inputs the DUT samples at the rising edge.
  task automatic tick();
    logic [1:0] e_sym;
    bit         e_rdy, e_sv, xfer, adv;
    #1;
    e_rdy = !clr && !m_pend;
    e_sv  = m_cur && !hold;
    e_sym = m_cur ? 2'(m_word >> (W - 2 - 2 * m_idx)) : 2'b00;
    chk("din_ready", 32'(din_ready), 32'(e_rdy));
    chk("B",         32'(B),         32'(e_sym[1]));
    chk("A",         32'(A),         32'(e_sym[0]));
    chk("sym_valid", 32'(sym_valid), 32'(e_sv));
    chk("last",      32'(last),      32'(e_sv && m_idx == N - 1));
    chk("busy",      32'(busy),      32'(m_cur || m_pend));
    if (sym_valid === 1'b1) sym_log.push_back({B, A});
    @(posedge clk);
    xfer = din_valid && e_rdy;
    adv  = m_cur && !hold;
    if (clr) begin
      m_cur = 1'b0; m_pend = 1'b0; m_idx = 0;
    end else if (adv && m_idx == N - 1) begin
      m_idx = 0;
      if (m_pend) begin
        m_word = m_pword; m_pend = 1'b0;
      end else if (xfer) begin
        m_word = din;
      end else begin
        m_cur = 1'b0;
      end
    end else begin
      if (adv) m_idx++;
      if (xfer) begin
        if (!m_cur) begin
          m_cur = 1'b1; m_word = din; m_idx = 0;
        end else begin
          m_pend = 1'b1; m_pword = din;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; din = '0; din_valid = 1'b0; hold = 1'b0;
    @(negedge clk); @(posedge clk); @(negedge clk);

    // 1. Reset hold-off with a word offered
    din_valid = 1'b1; din = 32'hC73B_9B1E;
    #1 chk("rst_ready", 32'(din_ready), 32'd0);
    repeat (3) tick();
    clr = 1'b0; din_valid = 1'b0;
    #1 chk("rel_ready", 32'(din_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    tick();

    // 2. Single word
    sym_log.delete();
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N) tick();
    chk("t2_count", 32'(sym_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sym_log.size(); i++)
      chk($sformatf("t2_sym%0d", i), 32'(sym_log[i]), 32'(ref_seq[i]));
    #1 chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_BA", 32'({B, A}), 32'd0);
    tick();

    // 3. Back-to-back words
    sym_log.delete();
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din = 32'hFFFF_0000;
    tick();
    din_valid = 1'b0;
    #1 chk("t3_ready_low", 32'(din_ready), 32'd0);
    repeat (2 * N - 1) tick();
    chk("t3_count", 32'(sym_log.size()), 32'd32);
    for (int i = 0; i < 32 && i < sym_log.size(); i++)
      chk($sformatf("t3_sym%0d", i), 32'(sym_log[i]),
          32'((i < 16) ? ref_seq[i] : ((i < 24) ? 2'd3 : 2'd0)));
    tick();

    // 4. Hold on symbol 5
    sym_log.delete();
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_sv", 32'(sym_valid), 32'd0);
      chk("t4_hold_BA", 32'({B, A}), 32'd3);
      tick();
    end
    hold = 1'b0;
    repeat (N - 5) tick();
    chk("t4_count", 32'(sym_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sym_log.size(); i++)
      chk($sformatf("t4_sym%0d", i), 32'(sym_log[i]), 32'(ref_seq[i]));

    // 5. Bypass on the last cycle
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N - 1) tick();
    din = 32'h5555_5555; din_valid = 1'b1;
    #1 chk("t5_last", 32'(last), 32'd1);
    chk("t5_ready", 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
    #1 chk("t5_sv", 32'(sym_valid), 32'd1);
    chk("t5_BA", 32'({B, A}), 32'd1);
    chk("t5_no_pend", 32'(din_ready), 32'd1);
    repeat (N) tick();

    // 6. Reset mid-word with a pending word
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din = 32'hFFFF_0000;
    tick();
    din_valid = 1'b0;
    repeat (7) tick();
    #1 chk("t6_sym8", 32'({B, A}), 32'(ref_seq[8]));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1 chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_BA", 32'({B, A}), 32'd0);
    sym_log.delete();
    din = 32'hC73B_9B1E; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (N + 2) tick();
    chk("t6_count", 32'(sym_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sym_log.size(); i++)
      chk($sformatf("t6_sym%0d", i), 32'(sym_log[i]), 32'(ref_seq[i]));

    // Randomized mixed traffic against the model
    for (int c = 0; c < 600; c++) begin
      clr       = ($urandom_range(0, 79) == 0);
      din_valid = ($urandom_range(0, 2) != 0);
      hold      = ($urandom_range(0, 3) == 0);
      din       = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
